// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, xlen_t, hit_t and wr_hit (write-port address match, highest port wins) for regfile_mp
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_MAX = 16;
  localparam int NWR_MAX = 8;
  localparam int WP_W = $clog2(NWR_MAX);
  localparam int WB_W = NWR_MAX * AW_MAX;
  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef struct packed {
    logic hit;
    logic [WP_W-1:0] idx;
  } hit_t;
  function automatic hit_t wr_hit(input logic [AW_MAX-1:0] addr, input logic [WB_W-1:0] waddr_bus,
                                  input logic [NWR_MAX-1:0] wren_bus, input int nwr, input int aw);
    hit_t r;
    logic [AW_MAX-1:0] m;
    r = '0;
    m = AW_MAX'((32'd1 << aw) - 32'd1);
    for (int j = 0; j < NWR_MAX; j++)
      if (j < nwr && wren_bus[j] && (AW_MAX'(waddr_bus >> (j * aw)) & m) == addr)
        r = '{hit: 1'b1, idx: WP_W'(j)};
    return r;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: register file bus (read addr/data/busy, write enable/addr/data, alloc); master drives requests, slave answers
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int NWR = 1
);
  localparam int AW = $clog2(NREG);
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0] rbusy;
  logic [NWR-1:0] wren;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;
  modport master (output raddr, wren, waddr, wdata, alloc_en, alloc_addr, input rdata, rbusy);
  modport slave (input raddr, wren, waddr, wdata, alloc_en, alloc_addr, output rdata, rbusy);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register, set by alloc_en/alloc_addr, cleared by any write in wren/waddr, alloc wins; out busy
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NWR-1:0] wren,
  input  logic [NWR*AW-1:0] waddr,
  input  logic alloc_en,
  input  logic [AW-1:0] alloc_addr,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] clr;
  hit_t h;
  always_comb begin
    clr = '0;
    h = '0;
    for (int i = 0; i < NREG; i++) begin
      h = wr_hit(AW_MAX'(i), WB_W'(waddr), NWR_MAX'(wren), NWR, AW);
      clr[i] = h.hit;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else
      for (int i = 0; i < NREG; i++)
        busy[i] <= (ZERO_REG != 0 && i == 0) ? 1'b0
                 : (alloc_en && alloc_addr == AW'(i)) || (busy[i] && !clr[i]);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read/NWR-write register file with busy scoreboard; ports i_clk, i_rst, bus (regfile_mp_if.slave); REGFILE_BYPASS_EN adds same-cycle write-through
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1
) (
  input logic i_clk,
  input logic i_rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] wd [NWR_MAX];
  logic [NREG-1:0] busy;
  hit_t whit [NREG];
  logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
  hit_t rh;
  logic byp;
`endif
  for (genvar j = 0; j < NWR_MAX; j++) begin : g_wd
    if (j < NWR) begin : g_on
      assign wd[j] = bus.wdata[j*XLEN +: XLEN];
    end else begin : g_off
      assign wd[j] = '0;
    end
  end
  always_comb
    for (int i = 0; i < NREG; i++)
      whit[i] = wr_hit(AW_MAX'(i), WB_W'(bus.waddr), NWR_MAX'(bus.wren), NWR, AW);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else
      for (int i = 0; i < NREG; i++)
        if (whit[i].hit && !(ZERO_REG != 0 && i == 0)) mem[i] <= wd[whit[i].idx];
  regfile_scoreboard #(.NREG(NREG), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(i_clk),
    .rst(i_rst),
    .wren(bus.wren),
    .waddr(bus.waddr),
    .alloc_en(bus.alloc_en),
    .alloc_addr(bus.alloc_addr),
    .busy(busy)
  );
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    ra = '0;
`ifdef REGFILE_BYPASS_EN
    rh = '0;
    byp = 1'b0;
`endif
    for (int k = 0; k < NRD; k++) begin
      ra = bus.raddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      rh = wr_hit(AW_MAX'(ra), WB_W'(bus.waddr), NWR_MAX'(bus.wren), NWR, AW);
      // the write-through path must not leak pending data while reset holds everything at zero
      byp = rh.hit && !i_rst;
      bus.rdata[k*XLEN +: XLEN] = (ZERO_REG != 0 && ra == '0) ? '0 : byp ? wd[rh.idx] : mem[ra];
      bus.rbusy[k] = (byp && !(bus.alloc_en && bus.alloc_addr == ra)) ? 1'b0 : busy[ra];
`else
      bus.rdata[k*XLEN +: XLEN] = (ZERO_REG != 0 && ra == '0) ? '0 : mem[ra];
      bus.rbusy[k] = busy[ra];
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (ZERO_REG=1/NWR=2 and ZERO_REG=0/NWR=1 instances)
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) ba ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1)) bb ();
  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(ba)
  );
  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .ZERO_REG(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bb)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    ba.wren = '0;
    ba.alloc_en = 1'b0;
    bb.wren = '0;
    bb.alloc_en = 1'b0;
  endtask
  initial begin
    ba.raddr = '0; ba.waddr = '0; ba.wdata = '0; ba.alloc_addr = '0;
    bb.raddr = '0; bb.waddr = '0; bb.wdata = '0; bb.alloc_addr = '0;
    idle();
    #1 rst = 1'b1;
    ba.raddr = {5'd7, 5'd5};
    #1;
    chk("rst_rd0", ba.rdata[31:0], 32'h0);
    chk("rst_rd1", ba.rdata[63:32], 32'h0);
    chk("rst_busy", 32'(ba.rbusy), 32'h0);
    @(negedge clk); rst = 1'b0;
    ba.wren = 2'b01; ba.waddr = {5'd0, 5'd5}; ba.wdata = {32'h0, 32'hDEADBEEF}; ba.raddr = {5'd0, 5'd5};
    #1 chk("wr5_same", ba.rdata[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    @(negedge clk); idle();
    #1 chk("wr5_next", ba.rdata[31:0], 32'hDEADBEEF);
    ba.wren = 2'b11; ba.waddr = {5'd7, 5'd7}; ba.wdata = {32'h2222, 32'h1111}; ba.raddr = {5'd7, 5'd0};
    #1 chk("wr7_same", ba.rdata[63:32], BYP ? 32'h2222 : 32'h0);
    chk("rd_zero", ba.rdata[31:0], 32'h0);
    @(negedge clk); idle();
    #1 chk("wr7_prio", ba.rdata[63:32], 32'h2222);
    ba.wren = 2'b11; ba.waddr = {5'd9, 5'd0}; ba.wdata = {32'h99, 32'hFFFF}; ba.raddr = {5'd9, 5'd0};
    #1 chk("wr0_same", ba.rdata[31:0], 32'h0);
    chk("wr9_same", ba.rdata[63:32], BYP ? 32'h99 : 32'h0);
    @(negedge clk); idle();
    #1 chk("wr0_drop", ba.rdata[31:0], 32'h0);
    chk("wr9_port1", ba.rdata[63:32], 32'h99);
    ba.alloc_en = 1'b1; ba.alloc_addr = 5'd3; ba.raddr = {5'd5, 5'd3};
    #1 chk("alloc3_same", 32'(ba.rbusy), 32'h0);
    @(negedge clk); idle();
    #1 chk("alloc3_next", 32'(ba.rbusy), 32'h1);
    ba.wren = 2'b01; ba.waddr = {5'd0, 5'd3}; ba.wdata = {32'h0, 32'h33};
    #1 chk("clr3_same", 32'(ba.rbusy), BYP ? 32'h0 : 32'h1);
    chk("wr3_same", ba.rdata[31:0], BYP ? 32'h33 : 32'h0);
    @(negedge clk); idle();
    #1 chk("clr3_next", 32'(ba.rbusy), 32'h0);
    chk("wr3_next", ba.rdata[31:0], 32'h33);
    ba.alloc_en = 1'b1; ba.alloc_addr = 5'd3;
    @(negedge clk); idle();
    #1 chk("realloc3", 32'(ba.rbusy), 32'h1);
    ba.alloc_en = 1'b1; ba.alloc_addr = 5'd3; ba.wren = 2'b10; ba.waddr = {5'd3, 5'd0}; ba.wdata = {32'h44, 32'h0};
    #1 chk("aw3_busy_same", 32'(ba.rbusy), 32'h1);
    chk("aw3_data_same", ba.rdata[31:0], BYP ? 32'h44 : 32'h33);
    @(negedge clk); idle();
    #1 chk("aw3_busy_next", 32'(ba.rbusy), 32'h1);
    chk("aw3_data_next", ba.rdata[31:0], 32'h44);
    ba.alloc_en = 1'b1; ba.alloc_addr = 5'd0; ba.raddr = {5'd3, 5'd0};
    bb.wren = 1'b1; bb.waddr = 5'd0; bb.wdata = 32'hABCD; bb.raddr = {5'd0, 5'd0};
    #1 chk("b_wr0_same", bb.rdata[31:0], BYP ? 32'hABCD : 32'h0);
    @(negedge clk); idle();
    bb.alloc_en = 1'b1; bb.alloc_addr = 5'd0;
    #1 chk("a_alloc0", 32'(ba.rbusy), 32'h2);
    chk("b_wr0", bb.rdata[31:0], 32'hABCD);
    chk("b_alloc0_same", 32'(bb.rbusy), 32'h0);
    @(negedge clk); idle();
    #1 chk("b_busy0", 32'(bb.rbusy), 32'h3);
    ba.wren = 2'b01; ba.waddr = {5'd0, 5'd10}; ba.wdata = {32'h0, 32'h1234};
    ba.alloc_en = 1'b1; ba.alloc_addr = 5'd11; ba.raddr = {5'd3, 5'd10};
    bb.wren = 1'b1; bb.waddr = 5'd1; bb.wdata = 32'h55; bb.raddr = {5'd1, 5'd0};
    #2 rst = 1'b1;
    #1 chk("rst_a_rd10", ba.rdata[31:0], 32'h0);
    chk("rst_a_rd3", ba.rdata[63:32], 32'h0);
    chk("rst_a_busy", 32'(ba.rbusy), 32'h0);
    chk("rst_b_rd0", bb.rdata[31:0], 32'h0);
    chk("rst_b_busy", 32'(bb.rbusy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; idle();
    @(negedge clk);
    ba.raddr = {5'd11, 5'd10};
    #1 chk("rst_wr10_drop", ba.rdata[31:0], 32'h0);
    chk("rst_alloc11_drop", 32'(ba.rbusy), 32'h0);
    chk("rst_b_wr1_drop", bb.rdata[63:32], 32'h0);
    ba.wren = 2'b01; ba.waddr = {5'd0, 5'd10}; ba.wdata = {32'h0, 32'h77};
    @(negedge clk); idle();
    #1 chk("post_rst_wr10", ba.rdata[31:0], 32'h77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
